// File: rtl/mini68k_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mini68k_pkg
//  Purpose  : Shared types and SR field positions for the Mini68k core blocks.
//  Revision : 1.0  initial release
// ============================================================================
package mini68k_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAVE   = 2'd1,
        ST_SETSR  = 2'd2,
        ST_VECTOR = 2'd3
    } irq_state_e;

    localparam int SR_T        = 15;
    localparam int SR_S        = 13;
    localparam int SR_IMASK_HI = 10;
    localparam int SR_IMASK_LO = 8;
    localparam int SR_CCR_HI   = 4;
    localparam int SR_CCR_LO   = 0;

    localparam logic [2:0] NMI_LEVEL = 3'd7;

    // Exception-entry SR: supervisor on, trace off, mask raised to the taken
    // level; every other field (including the CCR) is carried over.
    function automatic logic [15:0] build_entry_sr(input logic [15:0] old_sr,
                                                   input logic [2:0]  level);
        logic [15:0] r;
        r                           = old_sr;
        r[SR_T]                     = 1'b0;
        r[SR_S]                     = 1'b1;
        r[SR_IMASK_HI:SR_IMASK_LO]  = level;
        r[SR_CCR_HI:SR_CCR_LO]      = old_sr[SR_CCR_HI:SR_CCR_LO];
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mini68k_ipl_sync.sv
`default_nettype none
// ============================================================================
//  Module   : mini68k_ipl_sync
//  Purpose  : ipl_n synchronizer with a two-sample agreement filter and NMI
//             rising-edge detect.
//  Revision : 1.0  initial release
// ============================================================================
module mini68k_ipl_sync
    import mini68k_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] ipl_n,
    output logic [2:0] lvl_q,
    output logic       nmi_edge
);

    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic [SYNC_STAGES-1:0][2:0] sync_d;
    logic [2:0]                  prev_q;
    logic [2:0]                  prev_d;
    logic [2:0]                  lvl_d;
    logic [2:0]                  samp;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], ipl_n};
        samp     = sync_q[SYNC_STAGES-1];
        prev_d   = samp;
        lvl_d    = lvl_q;
        // Only accept a level seen on two consecutive synchronized samples.
        if (samp == prev_q) begin
            lvl_d = ~samp;
        end
        nmi_edge = (lvl_d == NMI_LEVEL) && (lvl_q != NMI_LEVEL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{3'b111}};
            prev_q <= 3'b111;
            lvl_q  <= 3'd0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            lvl_q  <= lvl_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mini68k_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mini68k_irq_ctrl
//  Purpose  : Interrupt entry controller: pending detection against the SR
//             mask, then stack old SR, write entry SR, issue autovector.
//  Revision : 1.0  initial release
// ============================================================================
module mini68k_irq_ctrl
    import mini68k_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int VECTOR_BASE = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  ipl_n,
    input  logic [15:0] sr_cur,
    output logic        irq_pending,
    output logic [2:0]  irq_level,
    input  logic        irq_ack,
    output logic [15:0] saved_sr,
    output logic        stack_req,
    input  logic        stack_done,
    output logic [15:0] sr_wdata,
    output logic        sr_we,
    output logic [7:0]  vector_num,
    output logic        vector_valid,
    output logic        busy
);

    localparam logic [7:0] VEC_BASE8 = 8'(VECTOR_BASE);

    irq_state_e  state_q, state_d;
    logic [2:0]  cap_lvl_q, cap_lvl_d;
    logic [15:0] saved_sr_q, saved_sr_d;
    logic        nmi_lat_q, nmi_lat_d;
    logic [2:0]  lvl_q;
    logic        nmi_edge;

    mini68k_ipl_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ipl_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .ipl_n    (ipl_n),
        .lvl_q    (lvl_q),
        .nmi_edge (nmi_edge)
    );

    always_comb begin
        state_d      = state_q;
        cap_lvl_d    = cap_lvl_q;
        saved_sr_d   = saved_sr_q;
        nmi_lat_d    = nmi_lat_q;
        stack_req    = 1'b0;
        sr_we        = 1'b0;
        sr_wdata     = 16'h0000;
        vector_valid = 1'b0;
        vector_num   = 8'h00;

        irq_pending = (state_q == ST_IDLE) && (lvl_q != 3'd0) &&
                      ((lvl_q > sr_cur[SR_IMASK_HI:SR_IMASK_LO]) || nmi_lat_q);
        irq_level   = (state_q == ST_IDLE) ? lvl_q : cap_lvl_q;

        unique case (state_q)
            ST_IDLE: begin
                if (irq_ack && irq_pending) begin
                    cap_lvl_d  = lvl_q;
                    saved_sr_d = sr_cur;
                    state_d    = ST_SAVE;
                end
            end
            ST_SAVE: begin
                stack_req = 1'b1;
                if (stack_done) begin
                    state_d = ST_SETSR;
                end
            end
            ST_SETSR: begin
                sr_we    = 1'b1;
                sr_wdata = build_entry_sr(saved_sr_q, cap_lvl_q);
                if (cap_lvl_q == NMI_LEVEL) begin
                    nmi_lat_d = 1'b0;
                end
                state_d = ST_VECTOR;
            end
            ST_VECTOR: begin
                vector_valid = 1'b1;
                vector_num   = VEC_BASE8 + {5'd0, cap_lvl_q};
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A fresh NMI edge always re-arms the latch, even while clearing.
        if (nmi_edge) begin
            nmi_lat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cap_lvl_q  <= 3'd0;
            saved_sr_q <= 16'h0000;
            nmi_lat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cap_lvl_q  <= cap_lvl_d;
            saved_sr_q <= saved_sr_d;
            nmi_lat_q  <= nmi_lat_d;
        end
    end

    assign saved_sr = saved_sr_q;
    assign busy     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mini68k_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mini68k_irq_ctrl
//  Purpose  : Directed scenarios plus randomized traffic against a
//             history-based reference model of the interrupt entry controller.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mini68k_irq_ctrl;

    localparam int SYNC  = 2;
    localparam int VBASE = 24;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  ipl_n;
    logic [15:0] sr_cur;
    logic        irq_ack;
    logic        stack_done;
    logic        irq_pending;
    logic [2:0]  irq_level;
    logic [15:0] saved_sr;
    logic        stack_req;
    logic [15:0] sr_wdata;
    logic        sr_we;
    logic [7:0]  vector_num;
    logic        vector_valid;
    logic        busy;

    always #5 clk = ~clk;

    mini68k_irq_ctrl #(
        .SYNC_STAGES (SYNC),
        .VECTOR_BASE (VBASE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ipl_n        (ipl_n),
        .sr_cur       (sr_cur),
        .irq_pending  (irq_pending),
        .irq_level    (irq_level),
        .irq_ack      (irq_ack),
        .saved_sr     (saved_sr),
        .stack_req    (stack_req),
        .stack_done   (stack_done),
        .sr_wdata     (sr_wdata),
        .sr_we        (sr_we),
        .vector_num   (vector_num),
        .vector_valid (vector_valid),
        .busy         (busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 idle, 1 stacking, 2 SR write, 3 vector.
    int          m_phase;
    logic [2:0]  m_lvl;
    logic [2:0]  m_cap;
    logic [15:0] m_saved;
    bit          m_nmi;
    logic [2:0]  hist[$];
    logic [15:0] sr_env;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_pending();
        return (m_phase == 0) && (m_lvl != 3'd0) && ((m_lvl > sr_cur[10:8]) || m_nmi);
    endfunction

    function automatic logic [15:0] exp_wdata();
        return (m_saved & 16'h58FF) | 16'h2000 | (16'(m_cap) << 8);
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_lvl   = 3'd0;
        m_cap   = 3'd0;
        m_saved = 16'h0000;
        m_nmi   = 1'b0;
        hist.delete();
        repeat (SYNC + 1) hist.push_back(3'b111);
    endtask

    // hist holds the ipl_n value present at the last SYNC+2 edges.
    task automatic model_update();
        logic       pend;
        logic [2:0] new_lvl;
        bit         new_nmi;
        if (!rst_n) begin
            model_reset();
            return;
        end
        pend = exp_pending();
        hist.push_back(ipl_n);
        new_lvl = (hist[1] == hist[0]) ? ~hist[1] : m_lvl;
        void'(hist.pop_front());
        new_nmi = m_nmi;
        if (m_phase == 2 && m_cap == 3'd7) new_nmi = 1'b0;
        if (new_lvl == 3'd7 && m_lvl != 3'd7) new_nmi = 1'b1;
        case (m_phase)
            0: if (irq_ack && pend) begin
                   m_cap   = m_lvl;
                   m_saved = sr_cur;
                   m_phase = 1;
               end
            1: if (stack_done) m_phase = 2;
            2: begin
                   sr_env  = exp_wdata();
                   m_phase = 3;
               end
            default: m_phase = 0;
        endcase
        m_lvl = new_lvl;
        m_nmi = new_nmi;
    endtask

    task automatic check_all();
        chk("busy",      32'(busy),         32'(m_phase != 0));
        chk("pending",   32'(irq_pending),  32'(exp_pending()));
        chk("level",     32'(irq_level),    32'((m_phase == 0) ? m_lvl : m_cap));
        chk("saved_sr",  32'(saved_sr),     32'(m_saved));
        chk("stack_req", 32'(stack_req),    32'(m_phase == 1));
        chk("sr_we",     32'(sr_we),        32'(m_phase == 2));
        chk("sr_wdata",  32'(sr_wdata),     32'((m_phase == 2) ? exp_wdata() : 16'h0));
        chk("vec_valid", 32'(vector_valid), 32'(m_phase == 3));
        chk("vec_num",   32'(vector_num),   32'((m_phase == 3) ? (VBASE + int'(m_cap)) : 0));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        sr_cur = sr_env;
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic set_sr(input logic [15:0] v);
        sr_env = v;
        sr_cur = v;
    endtask

    task automatic service(input int stall, input logic [2:0] ipl_during,
                           input logic [15:0] exp_saved, input logic [15:0] exp_wd,
                           input int exp_vec);
        int nreq;
        int nwe;
        nreq = 0;
        nwe  = 0;
        chk("dir_pending", 32'(irq_pending), 32'd1);
        irq_ack = 1'b1;
        tick();
        ipl_n = ipl_during;
        chk("dir_saved", 32'(saved_sr), 32'(exp_saved));
        repeat (stall) begin
            nreq += int'(stack_req);
            nwe  += int'(sr_we);
            tick();
        end
        nreq += int'(stack_req);
        stack_done = 1'b1;
        tick();
        stack_done = 1'b0;
        nwe += int'(sr_we);
        chk("dir_wdata", 32'(sr_wdata), 32'(exp_wd));
        tick();
        irq_ack = 1'b0;
        nwe += int'(sr_we);
        chk("dir_vvalid", 32'(vector_valid), 32'd1);
        chk("dir_vec", 32'(vector_num), 32'(exp_vec));
        tick();
        chk("dir_nreq", 32'(nreq), 32'(stall + 1));
        chk("dir_nwe", 32'(nwe), 32'd1);
        chk("dir_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout CHECKS %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int hold;
        int stall_cnt;
        rst_n      = 1'b0;
        ipl_n      = 3'b111;
        irq_ack    = 1'b0;
        stack_done = 1'b0;
        sr_env     = 16'h0000;
        sr_cur     = 16'h0000;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check_all();
        chk("rst_vec", 32'(vector_num), 32'd0);
        rst_n = 1'b1;

        // Maskable level 3 against mask 0: pending on the fourth edge.
        set_sr(16'h2000);
        ipl_n = 3'b100;
        run(3);
        chk("lat_early", 32'(irq_pending), 32'd0);
        tick();
        chk("lat_pend", 32'(irq_pending), 32'd1);
        chk("lat_level", 32'(irq_level), 32'd3);
        service(0, 3'b100, 16'h2000, 16'h2300, 27);
        run(3);
        chk("after_mask", 32'(irq_pending), 32'd0);

        // Level 5 masked by mask 5, level 6 taken.
        set_sr(16'h2500);
        ipl_n = 3'b010;
        run(6);
        chk("masked", 32'(irq_pending), 32'd0);
        ipl_n = 3'b001;
        run(5);
        service(0, 3'b001, 16'h2500, 16'h2600, 30);

        // NMI: edge-triggered against mask 7.
        set_sr(16'h2700);
        ipl_n = 3'b111;
        run(6);
        ipl_n = 3'b000;
        run(5);
        service(0, 3'b000, 16'h2700, 16'h2700, 31);
        run(10);
        chk("nmi_hold", 32'(irq_pending), 32'd0);
        ipl_n = 3'b100;
        run(6);
        ipl_n = 3'b000;
        run(6);
        chk("nmi_rearm", 32'(irq_pending), 32'd1);
        service(2, 3'b000, 16'h2700, 16'h2700, 31);

        // Glitch rejection, then a level change while stacking.
        set_sr(16'h2000);
        ipl_n = 3'b111;
        run(6);
        ipl_n = 3'b010;
        tick();
        ipl_n = 3'b111;
        run(6);
        chk("glitch", 32'(irq_level), 32'd0);
        ipl_n = 3'b101;
        run(5);
        service(3, 3'b001, 16'h2000, 16'h2200, 26);

        // Long stack stall and ack while nothing is pending.
        set_sr(16'h2000);
        ipl_n = 3'b011;
        run(5);
        service(10, 3'b011, 16'h2000, 16'h2400, 28);
        ipl_n = 3'b111;
        run(6);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("ack_ignored", 32'(busy), 32'd0);

        // Asynchronous reset while in the SR-write state.
        set_sr(16'h2000);
        ipl_n = 3'b010;
        run(6);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        stack_done = 1'b1;
        tick();
        stack_done = 1'b0;
        chk("pre_rst_we", 32'(sr_we), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_we", 32'(sr_we), 32'd0);
        chk("rst_wdata", 32'(sr_wdata), 32'd0);
        chk("rst_saved", 32'(saved_sr), 32'd0);
        chk("rst_level", 32'(irq_level), 32'd0);
        tick();
        rst_n = 1'b1;
        run(12);

        // Randomized traffic.
        hold      = 0;
        stall_cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            if (hold == 0) begin
                ipl_n = 3'($urandom_range(0, 7));
                hold  = ($urandom_range(0, 7) == 0) ? 1 : $urandom_range(2, 15);
            end
            hold--;
            irq_ack = ($urandom_range(0, 3) == 0);
            stack_done = 1'b0;
            if (m_phase == 1) begin
                if (stall_cnt == 0) begin
                    stack_done = 1'b1;
                    stall_cnt  = $urandom_range(0, 5);
                end else begin
                    stall_cnt--;
                end
            end
            if (m_phase == 0 && $urandom_range(0, 19) == 0) begin
                sr_env[10:8] = 3'($urandom_range(0, 7));
                sr_env[4:0]  = 5'($urandom_range(0, 31));
                sr_env[15]   = 1'($urandom_range(0, 1));
                sr_cur       = sr_env;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
